// File: rtl/y_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control sequencer.
package y_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True for the opcodes this sequencer knows how to step.
  function automatic logic opc_legal(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_LOAD) || (opc == OPC_IMM) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JAL);
  endfunction

endpackage

// File: rtl/y_alu_dec.sv
// Combinational instruction decode: ALU op, operand select and illegal flags.
module y_alu_dec
  import y_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] op,
  output logic       alu_src,
  output logic       opc_illegal,
  output logic       fn_illegal
);

  // Map opcode/funct fields to ALU controls; flag unsupported encodings.
  always_comb begin
    op          = ALU_ADD;
    alu_src     = 1'b0;
    opc_illegal = !opc_legal(opcode);
    fn_illegal  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct3)
          3'b000:  op = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b010:  op = ALU_SLT;
          default: fn_illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_IMM, OPC_STORE, OPC_JAL: begin
        alu_src = 1'b1;
      end
      OPC_BRANCH: begin
        op = ALU_SUB;
        if (funct3 != 3'b000 && funct3 != 3'b001) fn_illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multi-cycle control sequencer: owns pc/ir, steps FETCH/DECODE/EXEC/MEM/WB.
module y_mc_ctrl
  import y_ctrl_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_PC     = XLEN'(128),
  parameter int unsigned       RETIRE_LIMIT = 43
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] PCp4,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jTarget,
  input  logic            zero,
  input  logic            mem_ack,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ir,
  output logic            RegWrite,
  output logic            ALUSrc,
  output logic            Mem2Reg,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [2:0]      op,
  output logic [XLEN-1:0] retired,
  output logic            halted,
  output logic            trap
);

  localparam logic [XLEN-1:0] LIMIT = XLEN'(RETIRE_LIMIT);

  state_t          state;
  state_t          state_nxt;
  logic            retire;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] retired_inc;
  logic            limit_hit;
  logic            taken;

  logic [6:0] opcode;
  logic [2:0] dec_op;
  logic       dec_src;
  logic       opc_illegal;
  logic       fn_illegal;

  assign opcode = ir[6:0];

  y_alu_dec u_dec (
    .opcode      (opcode),
    .funct3      (ir[14:12]),
    .funct7_5    (ir[30]),
    .op          (dec_op),
    .alu_src     (dec_src),
    .opc_illegal (opc_illegal),
    .fn_illegal  (fn_illegal)
  );

  assign retired_inc = retired + XLEN'(1);
  assign limit_hit   = (LIMIT != '0) && (retired_inc == LIMIT);

  // Branch direction is the only path from zero; it is used only in EXEC.
  assign taken = (opcode == OPC_BRANCH) && (ir[12] ? !zero : zero);

  // Next pc on retire: branch offset in halfwords, jump offset in words.
  always_comb begin
    if (taken)                    pc_nxt = pc + (imm << 1);
    else if (opcode == OPC_JAL)   pc_nxt = pc + (jTarget << 2);
    else                          pc_nxt = PCp4;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and control outputs from registered state and ir.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    Mem2Reg   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    op        = '0;
    case (state)
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = opc_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        if (fn_illegal) begin
          state_nxt = ST_TRAP;
        end else begin
          ALUSrc = dec_src;
          op     = dec_op;
          case (opcode)
            OPC_LOAD, OPC_STORE: state_nxt = ST_MEM;
            OPC_BRANCH:          retire    = 1'b1;
            default:             state_nxt = ST_WB;
          endcase
        end
      end
      ST_MEM: begin
        ALUSrc   = dec_src;
        op       = dec_op;
        MemRead  = (opcode == OPC_LOAD);
        MemWrite = (opcode == OPC_STORE);
        if (mem_ack) begin
          if (opcode == OPC_LOAD) state_nxt = ST_WB;
          else                    retire    = 1'b1;
        end
      end
      ST_WB: begin
        ALUSrc   = dec_src;
        op       = dec_op;
        RegWrite = 1'b1;
        Mem2Reg  = (opcode == OPC_LOAD);
        retire   = 1'b1;
      end
      ST_HALT, ST_TRAP: ;
      default: state_nxt = ST_TRAP;
    endcase
    if (retire) state_nxt = limit_hit ? ST_HALT : ST_FETCH;
  end

  // Architectural registers: ir on fetch, pc/retired on retire, sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      retired <= '0;
      halted  <= 1'b0;
      trap    <= 1'b0;
    end else begin
      if (state == ST_FETCH) ir <= ins;
      if (retire) begin
        pc      <= pc_nxt;
        retired <= retired_inc;
      end
      if (state_nxt == ST_HALT || state_nxt == ST_TRAP) halted <= 1'b1;
      if (state_nxt == ST_TRAP) trap <= 1'b1;
    end
  end

endmodule
